pwm_multi_controller: RTL and testbench
=======================================

Name: pwm_multi_controller

Overview:
- N-channel fan PWM generator. One shared period counter drives it, advanced by a clock-enable tick.
- Each channel has a duty value plus a minimum-duty floor. All channel settings are double-buffered, so a new setting takes effect only at a period boundary and the output never glitches.
- Sits between the fan-control logic, which supplies the duty values, and the fan PWM pins. It replaces the single-channel PWM controller wherever more than one fan is driven.

Parameters:
- COUNTER_BITWIDTH, 8, width of each duty and min-duty value. The period and the counter are COUNTER_BITWIDTH+1 bits.
- CHANNELS, 4, number of independent PWM outputs (1..16).

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  reset, asynchronous, active-high.
- clk_en_i  input  1  counter tick enable.
- load_i  input  1  single-cycle strobe that captures all *_i settings into the pending registers.
- duty_i  input  CHANNELS*COUNTER_BITWIDTH  per-channel duty. Channel k occupies bits [k*W +: W].
- min_duty_i  input  CHANNELS*COUNTER_BITWIDTH  per-channel minimum-duty offset.
- period_i  input  COUNTER_BITWIDTH+1  shared terminal count. The period is period_i+1 ticks.
- ch_en_i  input  CHANNELS  per-channel enable.
- invert_i  input  CHANNELS  per-channel output polarity (1 = active-low pin).
- pending_o  output  1  high while captured settings are waiting for the next boundary.
- period_end_o  output  1  one-cycle pulse on each boundary.
- pwm_o  output  CHANNELS  PWM pins, registered.

Behaviour:
- Reset (async assert, sync release):
  - counter, active period and all active compares = 0.
  - pending registers = 0, pending_o = 0, period_end_o = 0.
  - active ch_en = 0, active invert = 0, so pwm_o = 0.
- Pending capture: on a clock with load_i=1, the pending registers capture duty_i, min_duty_i, period_i, ch_en_i and invert_i, and pending_o is set. A later load_i before a boundary overwrites the pending registers; the last load wins.
- Boundary: a clock with clk_en_i=1 and counter == active period.
  - counter <= 0 and period_end_o <= 1 for one cycle.
  - If pending_o=1, all pending values are copied to the active registers and pending_o is cleared.
- Load on the boundary cycle: if load_i=1 on a boundary cycle, the inputs on that cycle are transferred directly to the active registers and pending_o stays 0.
- Counting: on a non-boundary clock with clk_en_i=1, counter <= counter+1. With clk_en_i=0 the counter holds; load capture still operates.
- Compare arithmetic:
  - sum_k = duty_k + min_duty_k, computed at W+1 bits so it cannot overflow.
  - cmp_k = min(sum_k, period+1), computed at W+2 bits, and is calculated once, at transfer into the active registers.
  - cmp_k = 0 gives 0 % duty; cmp_k = period+1 gives 100 % duty.
- Output, evaluated every clock and registered:
  - raw_k = ch_en_k & (counter < cmp_k).
  - pwm_o[k] <= raw_k ^ invert_k.
  - pwm_o therefore lags the counter by one clock.
  - A disabled channel outputs invert_k, i.e. the inactive level.
- Period 0: the counter stays at 0 and every tick is a boundary. The output is high iff cmp_k ≥ 1.
- Counter wrap: the counter never exceeds the active period. If the period is reduced, the change takes effect only at a boundary, so counter > period cannot occur.

Optional Feature:
- Macro: PWM_CENTER_ALIGNED_EN.
- Defined:
  - The counter counts up 0→period, then down period→0. A direction flag is reset to up.
  - A boundary occurs when counter == 0 while counting down; transfer and period_end_o happen there.
  - The period becomes 2*(period+1) ticks.
  - Output comparison is unchanged, giving symmetric pulses.
  - period = 0 behaves as in edge-aligned mode.
- Undefined: edge-aligned counting as described above; the direction flag is absent.

Decomposition:
- Shared package pwm_pkg:
  - compare-width constants (W, W+1, W+2) and a saturating-add function.
  - the bundled channel-settings struct type (duty, min, enable, invert).
- Natural sub-module pwm_channel: holds one channel's active compare register and output flop, and is instantiated CHANNELS times.
- The top level holds the counter, the pending registers and the transfer logic.

Test Plan:
- Reset state: assert rst_i mid-period with outputs high → pwm_o, pending_o and period_end_o drop to 0 asynchronously; the counter restarts at 0 after release.
- Basic duty: period=9, ch0 duty=3 min=2, clk_en_i=1 → ch0 is high for 5 of every 10 ticks, delayed one clock from the counter, with period_end_o pulsing every 10 ticks.
- Saturation: period=9, duty=200, min=100 → cmp saturates to 10 and ch0 stays high continuously. With duty=0 and min=0 → ch0 stays low continuously.
- Double-buffering: load new duty at counter=4 → pending_o=1 and the output is unchanged until the boundary. The new duty applies from counter 0 of the next period, and pending_o clears on the boundary clock.
- Load on boundary and last-load-wins:
  - Two loads in one period → only the second takes effect.
  - A load exactly on the boundary cycle → applied immediately, pending_o never rises.
- Enable and invert: ch_en=0 with invert=1 → pin held high. clk_en_i=0 for 20 clocks → counter and outputs frozen.
- Center-aligned, when built with PWM_CENTER_ALIGNED_EN: period=4, cmp=2 → 10-tick period, high at counts 0,1 on the up slope and 1,0 on the down slope.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared widths, channel-settings bundle and compare saturation for the multi-channel PWM.
package pwm_pkg;
    localparam int PWM_W  = 8;
    localparam int PWM_W1 = PWM_W + 1;
    localparam int PWM_W2 = PWM_W + 2;

    typedef struct packed {
        logic [PWM_W-1:0] duty;
        logic [PWM_W-1:0] min_duty;
        logic             en;
        logic             inv;
    } ch_cfg_t;

    // min(duty + min_duty, period + 1); the sum is widened first so it cannot wrap
    function automatic logic [PWM_W2-1:0] sat_cmp(input logic [PWM_W-1:0]  duty,
                                                  input logic [PWM_W-1:0]  min_duty,
                                                  input logic [PWM_W1-1:0] period);
        logic [PWM_W1-1:0] sum;
        logic [PWM_W2-1:0] lim;
        sum = {1'b0, duty} + {1'b0, min_duty};
        lim = {1'b0, period} + PWM_W2'(1);
        return ({1'b0, sum} < lim) ? {1'b0, sum} : lim;
    endfunction
endpackage

// File: rtl/pwm_multi_controller_channel.sv
// One PWM channel: active compare/enable/polarity registers and the registered output pin.
module pwm_channel
    import pwm_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              xfer_i,
    input  logic [PWM_W2-1:0] cmp_i,
    input  logic              en_i,
    input  logic              inv_i,
    input  logic [PWM_W1-1:0] cnt_i,
    output logic              pwm_o
);
    logic [PWM_W2-1:0] cmp_q;
    logic              en_q;
    logic              inv_q;
    logic              pwm_q;
    logic              pwm_d;

    assign pwm_d = (en_q & ({1'b0, cnt_i} < cmp_q)) ^ inv_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmp_q <= '0;
            en_q  <= 1'b0;
            inv_q <= 1'b0;
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= pwm_d;
            if (xfer_i) begin
                cmp_q <= cmp_i;
                en_q  <= en_i;
                inv_q <= inv_i;
            end
        end
    end

    assign pwm_o = pwm_q;
endmodule

// File: rtl/pwm_multi_controller.sv
// N-channel fan PWM with a shared period counter and boundary-synchronous setting updates.
// Macro PWM_CENTER_ALIGNED_EN selects up/down counting. COUNTER_BITWIDTH must equal pwm_pkg::PWM_W.
module pwm_multi_controller
    import pwm_pkg::*;
#(
    parameter int COUNTER_BITWIDTH = PWM_W,
    parameter int CHANNELS         = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 clk_en_i,
    input  logic                                 load_i,
    input  logic [CHANNELS*COUNTER_BITWIDTH-1:0] duty_i,
    input  logic [CHANNELS*COUNTER_BITWIDTH-1:0] min_duty_i,
    input  logic [COUNTER_BITWIDTH:0]            period_i,
    input  logic [CHANNELS-1:0]                  ch_en_i,
    input  logic [CHANNELS-1:0]                  invert_i,
    output logic                                 pending_o,
    output logic                                 period_end_o,
    output logic [CHANNELS-1:0]                  pwm_o
);
    localparam int         W       = COUNTER_BITWIDTH;
    localparam logic [W:0] CNT_ONE = {{W{1'b0}}, 1'b1};

    logic [W:0] cnt_q, cnt_d;
    logic [W:0] period_q;
    logic [W:0] pend_period_q;
    logic       pending_q;
    logic       period_end_q;
    logic       boundary;
    logic       xfer;
    logic [W:0] xfer_period;
    ch_cfg_t    in_cfg      [CHANNELS];
    ch_cfg_t    pend_cfg_q  [CHANNELS];
    ch_cfg_t    xfer_cfg    [CHANNELS];
`ifdef PWM_CENTER_ALIGNED_EN
    logic       dir_q, dir_d;
`endif

    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            in_cfg[k] = '{duty:     duty_i[k*W +: W],
                          min_duty: min_duty_i[k*W +: W],
                          en:       ch_en_i[k],
                          inv:      invert_i[k]};
        end
    end

`ifdef PWM_CENTER_ALIGNED_EN
    // Both end points are held for one tick, giving 2*(period+1) ticks per period.
    always_comb begin
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        boundary = 1'b0;
        if (clk_en_i) begin
            if (period_q == '0) begin
                boundary = 1'b1;
            end else if (!dir_q) begin
                if (cnt_q == period_q) dir_d = 1'b1;
                else                   cnt_d = cnt_q + CNT_ONE;
            end else if (cnt_q == '0) begin
                boundary = 1'b1;
                dir_d    = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
            if (boundary) cnt_d = '0;
        end
    end
`else
    always_comb begin
        cnt_d    = cnt_q;
        boundary = clk_en_i && (cnt_q == period_q);
        if (clk_en_i) cnt_d = boundary ? '0 : cnt_q + CNT_ONE;
    end
`endif

    // A load on the boundary bypasses the pending stage.
    assign xfer        = boundary && (load_i || pending_q);
    assign xfer_period = load_i ? period_i : pend_period_q;

    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            xfer_cfg[k] = load_i ? in_cfg[k] : pend_cfg_q[k];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q         <= '0;
            period_q      <= '0;
            pend_period_q <= '0;
            pending_q     <= 1'b0;
            period_end_q  <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) pend_cfg_q[k] <= '0;
`ifdef PWM_CENTER_ALIGNED_EN
            dir_q         <= 1'b0;
`endif
        end else begin
            cnt_q        <= cnt_d;
            period_end_q <= boundary;
`ifdef PWM_CENTER_ALIGNED_EN
            dir_q        <= dir_d;
`endif
            if (xfer) period_q <= xfer_period;
            if (boundary) begin
                pending_q <= 1'b0;
            end else if (load_i) begin
                pending_q     <= 1'b1;
                pend_period_q <= period_i;
                pend_cfg_q    <= in_cfg;
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [PWM_W2-1:0] cmp_d;
        assign cmp_d = sat_cmp(xfer_cfg[k].duty, xfer_cfg[k].min_duty, xfer_period);

        pwm_channel u_ch (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .xfer_i (xfer),
            .cmp_i  (cmp_d),
            .en_i   (xfer_cfg[k].en),
            .inv_i  (xfer_cfg[k].inv),
            .cnt_i  (cnt_q),
            .pwm_o  (pwm_o[k])
        );
    end

    assign pending_o    = pending_q;
    assign period_end_o = period_end_q;
endmodule

// File: tb/tb_pwm_multi_controller.sv
// Directed bench for pwm_multi_controller: per-period duty vectors plus buffering/reset/freeze sequences.
module tb_pwm_multi_controller;
    localparam int W  = 8;
    localparam int CH = 4;
`ifdef PWM_CENTER_ALIGNED_EN
    localparam bit CENTER = 1'b1;
`else
    localparam bit CENTER = 1'b0;
`endif

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            clk_en_i;
    logic            load_i;
    logic [CH*W-1:0] duty_i;
    logic [CH*W-1:0] min_duty_i;
    logic [W:0]      period_i;
    logic [CH-1:0]   ch_en_i;
    logic [CH-1:0]   invert_i;
    logic            pending_o;
    logic            period_end_o;
    logic [CH-1:0]   pwm_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    pwm_multi_controller #(.COUNTER_BITWIDTH(W), .CHANNELS(CH)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clk_en_i     (clk_en_i),
        .load_i       (load_i),
        .duty_i       (duty_i),
        .min_duty_i   (min_duty_i),
        .period_i     (period_i),
        .ch_en_i      (ch_en_i),
        .invert_i     (invert_i),
        .pending_o    (pending_o),
        .period_end_o (period_end_o),
        .pwm_o        (pwm_o)
    );

    typedef struct packed {
        logic [8:0]           period;
        logic [CH-1:0][7:0]   duty;
        logic [CH-1:0][7:0]   mind;
        logic [CH-1:0]        en;
        logic [CH-1:0]        inv;
        logic [CH-1:0][15:0]  raw_hi;
    } vec_t;

    vec_t vecs [5];

    function automatic int plen(input int p);
        return (CENTER && p != 0) ? 2 * (p + 1) : p + 1;
    endfunction

    function automatic int cnt_at(input int t, input int p);
        if (CENTER && p != 0 && t > p) return 2 * p + 1 - t;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic wait_pe(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (period_end_o !== 1'b1 && n < 2100);
        check({name, "_boundary_seen"}, period_end_o, 1'b1);
    endtask

    // ch1 enabled at 0 %, ch2 disabled+inverted (pin high), ch3 disabled (pin low)
    task automatic set_seq_cfg(input logic [7:0] d0, input logic [7:0] m0, input logic [8:0] p);
        duty_i          = '0;
        min_duty_i      = '0;
        duty_i[7:0]     = d0;
        min_duty_i[7:0] = m0;
        period_i        = p;
        ch_en_i         = 4'b0011;
        invert_i        = 4'b0100;
    endtask

    // Requires active period 0 (fresh from reset), so the load lands on a boundary.
    task automatic restart_seq(input string tag);
        int len;
        logic ch0;
        len = plen(9);
        set_seq_cfg(8'd3, 8'd2, 9'd9);
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
        check({tag, "_bload_pending"}, pending_o, 1'b0);
        check({tag, "_bload_pe"}, period_end_o, 1'b1);
        check({tag, "_bload_pwm"}, pwm_o, 4'b0000);
        for (int j = 1; j <= len; j++) begin
            tick();
            ch0 = (cnt_at(j - 1, 9) < 5);
            check({tag, "_pattern_pwm"}, pwm_o, {1'b0, 1'b1, 1'b0, ch0});
            check({tag, "_pattern_pe"}, period_end_o, (j == len));
        end
        check({tag, "_pending_low"}, pending_o, 1'b0);
    endtask

    initial begin
        int t, len, hi, pe_cnt, pin_exp, raw;
        int hi_cnt [CH];
        logic ch0;

        vecs[0] = '{period: 9'd9,   duty: {8'd7, 8'd0, 8'd200, 8'd3},   mind: {8'd0, 8'd0, 8'd100, 8'd2},
                    en: 4'b0111, inv: 4'b1000, raw_hi: {16'd0, 16'd0, 16'd10, 16'd5}};
        vecs[1] = '{period: 9'd0,   duty: {8'd255, 8'd0, 8'd0, 8'd1},   mind: {8'd255, 8'd0, 8'd0, 8'd0},
                    en: 4'b1111, inv: 4'b0100, raw_hi: {16'd1, 16'd0, 16'd0, 16'd1}};
        vecs[2] = '{period: 9'd255, duty: {8'd0, 8'd10, 8'd255, 8'd128}, mind: {8'd50, 8'd5, 8'd255, 8'd0},
                    en: 4'b1111, inv: 4'b0100, raw_hi: {16'd50, 16'd15, 16'd256, 16'd128}};
        vecs[3] = '{period: 9'd511, duty: {8'd255, 8'd0, 8'd100, 8'd255}, mind: {8'd0, 8'd1, 8'd0, 8'd255},
                    en: 4'b0111, inv: 4'b0000, raw_hi: {16'd0, 16'd1, 16'd100, 16'd510}};
        vecs[4] = '{period: 9'd4,   duty: {8'd0, 8'd1, 8'd3, 8'd2},     mind: {8'd0, 8'd1, 8'd3, 8'd0},
                    en: 4'b0111, inv: 4'b0000, raw_hi: {16'd0, 16'd2, 16'd5, 16'd2}};

        rst_i      = 1'b1;
        clk_en_i   = 1'b0;
        load_i     = 1'b0;
        duty_i     = '0;
        min_duty_i = '0;
        period_i   = '0;
        ch_en_i    = '0;
        invert_i   = '0;
        repeat (3) tick();
        check("reset_pwm", pwm_o, 4'b0000);
        check("reset_pending", pending_o, 1'b0);
        check("reset_pe", period_end_o, 1'b0);
        @(negedge clk_i);
        rst_i    = 1'b0;
        clk_en_i = 1'b1;
        tick();

        // counter restart, exact 5-of-10 pattern, load on boundary
        restart_seq("start");

        // double buffering and last-load-wins
        len = plen(9);
        t = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("dbuf_pre_ch0", pwm_o[0], (cnt_at(t, 9) < 5));
            t++;
        end
        set_seq_cfg(8'd1, 8'd0, 9'd9);
        load_i = 1'b1;
        tick();
        check("dbuf_load1_ch0", pwm_o[0], (cnt_at(t, 9) < 5));
        t++;
        check("dbuf_load1_pending", pending_o, 1'b1);
        set_seq_cfg(8'd7, 8'd1, 9'd9);
        tick();
        t++;
        load_i = 1'b0;
        check("dbuf_load2_pending", pending_o, 1'b1);
        while (t < len) begin
            tick();
            check("dbuf_old_ch0", pwm_o[0], (cnt_at(t, 9) < 5));
            t++;
        end
        check("dbuf_boundary_pe", period_end_o, 1'b1);
        check("dbuf_boundary_pending", pending_o, 1'b0);
        hi = 0;
        for (int j = 0; j < len; j++) begin
            tick();
            hi += int'(pwm_o[0]);
        end
        check("dbuf_last_load_highs", hi, CENTER ? 16 : 8);
        check("dbuf_next_pe", period_end_o, 1'b1);

        // clk_en low freezes counter and outputs
        t = 0;
        repeat (2) begin
            tick();
            t++;
        end
        clk_en_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("freeze_pwm", pwm_o, {1'b0, 1'b1, 1'b0, 1'b1});
            check("freeze_pe", period_end_o, 1'b0);
        end
        clk_en_i = 1'b1;
        while (t < len) begin
            tick();
            ch0 = (cnt_at(t, 9) < 8);
            check("resume_pwm", pwm_o, {1'b0, 1'b1, 1'b0, ch0});
            t++;
        end
        check("resume_pe", period_end_o, 1'b1);

        // per-period high counts, all channels
        for (int v = 0; v < 5; v++) begin
            duty_i     = vecs[v].duty;
            min_duty_i = vecs[v].mind;
            period_i   = vecs[v].period;
            ch_en_i    = vecs[v].en;
            invert_i   = vecs[v].inv;
            load_i     = 1'b1;
            tick();
            load_i = 1'b0;
            wait_pe($sformatf("vec%0d", v));
            len = plen(int'(vecs[v].period));
            for (int k = 0; k < CH; k++) hi_cnt[k] = 0;
            pe_cnt = 0;
            for (int j = 0; j < len; j++) begin
                tick();
                for (int k = 0; k < CH; k++) hi_cnt[k] += int'(pwm_o[k]);
                pe_cnt += int'(period_end_o);
            end
            for (int k = 0; k < CH; k++) begin
                raw = int'(vecs[v].raw_hi[k]);
                if (CENTER && vecs[v].period != 0) raw = 2 * raw;
                pin_exp = vecs[v].inv[k] ? len - raw : raw;
                check($sformatf("vec%0d_ch%0d_highs", v, k), hi_cnt[k], pin_exp);
            end
            check($sformatf("vec%0d_pe_count", v), pe_cnt, 1);
            check($sformatf("vec%0d_pe_last", v), period_end_o, 1'b1);
        end

        // asynchronous reset mid-period with outputs high and a load pending
        tick();
        set_seq_cfg(8'd3, 8'd2, 9'd9);
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
        check("midrst_pre_pending", pending_o, 1'b1);
        check("midrst_pre_ch1", pwm_o[1], 1'b1);
        #2;
        rst_i = 1'b1;
        #1;
        check("midrst_pwm", pwm_o, 4'b0000);
        check("midrst_pending", pending_o, 1'b0);
        check("midrst_pe", period_end_o, 1'b0);
        repeat (2) tick();
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        restart_seq("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
